// File: rtl/clock_adjust_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | clock_adj_pkg : shared state encoding and default timing constants  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package clock_adj_pkg;

  typedef enum logic [0:0] {
    NORM = 1'b0,
    ADJ  = 1'b1
  } state_t;

  localparam int DEF_REP_DLY = 500;
  localparam int DEF_REP_PER = 100;
  localparam int DEF_TIMEOUT = 30000;

endpackage

`default_nettype wire

// File: rtl/clock_adjust_ctrl_if.sv
// +--------------------------------------------------------------------+
// | clock_adjust_ctrl_if : buttons in, field strobes/enables out         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface clock_adjust_ctrl_if #(
  parameter int NFIELD = 3
);
  logic              sig2hz;
  logic              mode;
  logic              select;
  logic              adjust;
  logic [NFIELD-1:0] fldinc;
  logic [NFIELD-1:0] fldclr;
  logic [NFIELD-1:0] fldon;
  logic              adjmode;

  modport master (
    output sig2hz, mode, select, adjust,
    input  fldinc, fldclr, fldon, adjmode
  );

  modport slave (
    input  sig2hz, mode, select, adjust,
    output fldinc, fldclr, fldon, adjmode
  );
endinterface

`default_nettype wire

// File: rtl/clock_adjust_ctrl_adj_repeat.sv
// +--------------------------------------------------------------------+
// | adj_repeat : ADJUST edge pulse plus hold-to-repeat pulse train      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module adj_repeat
  import clock_adj_pkg::*;
#(
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic adjust,
  input  wire logic kill,
  output logic      edgep,
  output logic      adjp
);

  localparam int C_CMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int C_CW   = $clog2(C_CMAX + 1);

  logic            r_prev;
  logic            r_rep;
  logic            r_edgep;
  logic            r_adjp;
  logic [C_CW-1:0] r_cnt;
  logic            w_rise;
  logic            w_hit;

  // r_cnt==0 means disarmed: a killed press stays silent until re-pressed
  assign w_rise = adjust & ~r_prev;
  assign w_hit  = adjust & (r_cnt != '0) &
                  (r_rep ? (r_cnt == C_CW'(REP_PER)) : (r_cnt == C_CW'(REP_DLY)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b1;
      r_rep   <= 1'b0;
      r_cnt   <= '0;
      r_edgep <= 1'b0;
      r_adjp  <= 1'b0;
    end else begin
      r_prev  <= adjust;
      r_edgep <= w_rise & ~kill;
      r_adjp  <= (w_rise | w_hit) & ~kill;
      if (!adjust || kill) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_rise) begin
        r_cnt <= C_CW'(1);
        r_rep <= 1'b0;
      end else if (w_hit) begin
        r_cnt <= C_CW'(1);
        r_rep <= 1'b1;
      end else if (r_cnt != '0 && r_cnt != C_CW'(C_CMAX)) begin
        r_cnt <= r_cnt + C_CW'(1);
      end
    end
  end

  assign edgep = r_edgep;
  assign adjp  = r_adjp;

endmodule

`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
// +--------------------------------------------------------------------+
// | clock_adjust_ctrl : NORM/ADJ time-set FSM with field strobes/blink  |
// | Optional ADJ idle timeout when ADJ_TIMEOUT_EN is defined.  Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_adjust_ctrl
  import clock_adj_pkg::*;
#(
  parameter int                NFIELD   = 3,
  parameter logic [NFIELD-1:0] CLR_MASK = NFIELD'(1),
  parameter int                REP_DLY  = DEF_REP_DLY,
  parameter int                REP_PER  = DEF_REP_PER,
  parameter int                TIMEOUT  = DEF_TIMEOUT
) (
  input wire logic          clk,
  input wire logic          rst,
  clock_adjust_ctrl_if.slave bus
);

  localparam int C_FW = $clog2(NFIELD);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [C_FW-1:0]   r_fld;
  logic [C_FW-1:0]   w_fld_nxt;
  logic              w_kill;
  logic              w_edgep;
  logic              w_adjp;
  logic              w_timeout;
  logic [NFIELD-1:0] w_inc;
  logic [NFIELD-1:0] w_clr;
  logic [NFIELD-1:0] w_on;

  assign w_kill = bus.mode | bus.select;

  adj_repeat #(
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_adj_repeat (
    .clk    (clk),
    .rst    (rst),
    .adjust (bus.adjust),
    .kill   (w_kill),
    .edgep  (w_edgep),
    .adjp   (w_adjp)
  );

`ifdef ADJ_TIMEOUT_EN
  localparam int C_IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [C_IW-1:0] r_idle;
  logic            w_active;

  assign w_active  = bus.mode | bus.select | bus.adjust;
  assign w_timeout = (r_state == ADJ) && !w_active && (r_idle == C_IW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state != ADJ || w_active || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + C_IW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NORM;
      r_fld   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fld   <= w_fld_nxt;
    end
  end

  // MODE outranks SELECT; SELECT in NORM is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_fld_nxt   = r_fld;
    case (r_state)
      NORM: begin
        if (bus.mode) begin
          w_state_nxt = ADJ;
          w_fld_nxt   = '0;
        end
      end
      ADJ: begin
        if (bus.mode) begin
          w_state_nxt = NORM;
        end else if (bus.select) begin
          w_fld_nxt = (r_fld == C_FW'(NFIELD - 1)) ? '0 : r_fld + C_FW'(1);
        end else if (w_timeout) begin
          w_state_nxt = NORM;
        end
      end
      default: w_state_nxt = NORM;
    endcase
  end

  always_comb begin
    w_inc = '0;
    w_clr = '0;
    w_on  = '1;
    for (int i = 0; i < NFIELD; i++) begin
      if (r_state == ADJ && r_fld == C_FW'(i)) begin
        w_inc[i] = w_adjp & ~CLR_MASK[i];
        w_clr[i] = w_edgep & CLR_MASK[i];
        w_on[i]  = ~bus.sig2hz;
      end
    end
  end

  assign bus.fldinc  = w_inc;
  assign bus.fldclr  = w_clr;
  assign bus.fldon   = w_on;
  assign bus.adjmode = (r_state == ADJ);

endmodule

`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_clock_adjust_ctrl : directed + random bench with reference model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_clock_adjust_ctrl;

  localparam int       NFIELD   = 3;
  localparam logic [2:0] CLR    = 3'b001;
  localparam int       REP_DLY  = 4;
  localparam int       REP_PER  = 2;
  localparam int       TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clock_adjust_ctrl_if #(.NFIELD(NFIELD)) bus ();

  clock_adjust_ctrl #(
    .NFIELD   (NFIELD),
    .CLR_MASK (CLR),
    .REP_DLY  (REP_DLY),
    .REP_PER  (REP_PER),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model: state after each sampled posedge
  bit m_adj, m_prev, m_armed, m_adjp, m_edgep;
  int m_fld, m_held, m_idle;

  task automatic model_update();
    bit rise, kill, act;
    if (rst) begin
      m_adj = 0; m_fld = 0; m_prev = 1; m_armed = 0; m_held = 0;
      m_adjp = 0; m_edgep = 0; m_idle = 0;
    end else begin
      rise   = bus.adjust && !m_prev;
      m_prev = bus.adjust;
      kill   = bus.mode || bus.select;
      act    = kill || bus.adjust;
      if (!bus.adjust || kill) begin
        m_armed = 0; m_held = 0;
      end else if (rise) begin
        m_armed = 1; m_held = 1;
      end else if (m_armed) begin
        m_held++;
      end
      m_edgep = m_armed && (m_held == 1);
      m_adjp  = m_armed && (m_held == 1 || m_held == 1 + REP_DLY ||
                (m_held > 1 + REP_DLY && ((m_held - 1 - REP_DLY) % REP_PER) == 0));
      if (!m_adj) begin
        m_idle = 0;
        if (bus.mode) begin m_adj = 1; m_fld = 0; end
      end else if (bus.mode) begin
        m_adj = 0; m_idle = 0;
      end else if (bus.select) begin
        m_fld = (m_fld + 1) % NFIELD; m_idle = 0;
      end else begin
`ifdef ADJ_TIMEOUT_EN
        if (act) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_adj = 0; m_idle = 0; end
        end
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
  end

  int cyc = 0;
  initial forever begin
    logic [9:0] exp_v, act_v;
    logic [2:0] e_inc, e_clr, e_on, onehot;
    @(posedge clk);
    #1;
    cyc++;
    onehot = 3'b001 << m_fld;
    e_inc  = (m_adj && m_adjp  && !CLR[m_fld]) ? onehot : 3'b000;
    e_clr  = (m_adj && m_edgep &&  CLR[m_fld]) ? onehot : 3'b000;
    e_on   = (m_adj && bus.sig2hz) ? ~onehot : 3'b111;
    exp_v  = {e_inc, e_clr, e_on, m_adj};
    act_v  = {bus.fldinc, bus.fldclr, bus.fldon, bus.adjmode};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model cycle %0d inc/clr/on/adj actual=%b required=%b", cyc, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic s, input logic a, input logic z);
    @(negedge clk);
    rst = r; bus.mode = m; bus.select = s; bus.adjust = a; bus.sig2hz = z;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n, ni;
    logic [31:0] mask;
    logic a;
    bus.mode = 0; bus.select = 0; bus.adjust = 1; bus.sig2hz = 0;

    // reset with ADJUST held through it
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("reset_inc", {29'd0, bus.fldinc}, 0);
    chk("reset_clr", {29'd0, bus.fldclr}, 0);
    chk("reset_on", {29'd0, bus.fldon}, 32'h7);
    chk("reset_adjmode", {31'd0, bus.adjmode}, 0);

    step(0, 1, 0, 1, 0);
    chk("enter_adj", {31'd0, bus.adjmode}, 1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 1, 0);
      if (bus.fldclr != 0) n++;
    end
    chk("held_through_reset", n, 0);
    step(0, 0, 0, 0, 0);

    // clear field: one edge pulse only
    n = 0; ni = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1, 0);
      if (bus.fldclr == 3'b001) n++;
      if (bus.fldinc != 0) ni++;
    end
    chk("clr_once", n, 1);
    chk("clr_noinc", ni, 0);

    // navigation with blink
    step(0, 0, 0, 0, 1); chk("nav_fld0", {29'd0, bus.fldon}, 32'h6);
    step(0, 0, 1, 0, 1); chk("nav_fld1", {29'd0, bus.fldon}, 32'h5);
    step(0, 0, 1, 0, 1); chk("nav_fld2", {29'd0, bus.fldon}, 32'h3);
    step(0, 0, 1, 0, 1); chk("nav_wrap", {29'd0, bus.fldon}, 32'h6);
    step(0, 1, 0, 0, 1);
    chk("norm_on", {29'd0, bus.fldon}, 32'h7);
    chk("norm_adjmode", {31'd0, bus.adjmode}, 0);

    // hold-to-repeat on field 1
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    mask = 0;
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 1, 0);
      if (bus.fldinc == 3'b010) mask[k] = 1'b1;
    end
    chk("repeat_times", mask, 32'h0AA2);
    ni = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      if (bus.fldinc != 0) ni++;
    end
    chk("repeat_release", ni, 0);

    // collisions
    step(0, 1, 1, 0, 0);
    chk("mode_select", {31'd0, bus.adjmode}, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("select_adj_on", {29'd0, bus.fldon}, 32'h5);
    chk("select_adj_inc", {29'd0, bus.fldinc}, 0);
    step(0, 0, 0, 0, 0);

    // idle timeout
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
`ifdef ADJ_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(0, 0, 0, 0, 0);
      if (k < TIMEOUT && bus.adjmode != 1'b1) n++;
    end
    chk("timeout_hold", n, 0);
    chk("timeout_exit", {31'd0, bus.adjmode}, 0);
`else
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 0);
    chk("no_timeout", {31'd0, bus.adjmode}, 1);
`endif

    // randomized traffic, checked every cycle by the model
    a = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) a = ~a;
      step(($urandom_range(199) == 0), ($urandom_range(15) == 0),
           ($urandom_range(7) == 0), a, 1'($urandom_range(1)));
    end

    step(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
